// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline run/step/halt sequencer.
package pipeline_pkg;

    // Sequencer states; the encoding is exposed on the debug state port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        FLUSH  = 3'd3,
        HALTED = 3'd4
    } state_t;

    // Debug front-end command codes.
    typedef enum logic [1:0] {
        CMD_RUN   = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_STOP  = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_t;

    // Reserved opcode; the control unit must never decode it as anything else.
    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    // Width of the flush down-counter (flush length 1..15).
    localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer: gates the global pipeline enable, drives a
// multi-cycle flush, freezes on HALT retirement and counts enabled cycles.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             wb_valid,
    input  logic [5:0]       wb_opcode,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state
);

    state_t                 state_reg, state_next;
    logic [FLUSH_CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic                   accept;
    logic                   halt_hit;
    logic                   flush_start;
    cmd_t                   cmd_code;

    // Moore outputs decoded from the registered state.
    assign pipe_en    = (state_reg == RUN) || (state_reg == STEP);
    assign pipe_flush = (state_reg == FLUSH);
    assign halted     = (state_reg == HALTED);
    assign busy       = (state_reg == RUN) || (state_reg == STEP) || (state_reg == FLUSH);
    assign cmd_ready  = (state_reg == IDLE) || (state_reg == RUN) || (state_reg == HALTED);
    assign state      = state_reg;

    assign cmd_code    = cmd_t'(cmd);
    assign accept      = cmd_valid && cmd_ready;
    // Only a HALT that actually retires (pipeline advancing) counts.
    assign halt_hit    = pipe_en && wb_valid && (wb_opcode == HALT_OPCODE);
    assign flush_start = (state_next == FLUSH) && (state_reg != FLUSH);

    // State and flush down-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    // Next-state logic; HALT retirement overrides any command accepted in the same cycle.
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (cmd_code)
                        CMD_RUN:   state_next = RUN;
                        CMD_STEP:  state_next = STEP;
                        CMD_FLUSH: state_next = FLUSH;
                        default:   state_next = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (accept) begin
                    case (cmd_code)
                        CMD_STOP:  state_next = IDLE;
                        CMD_FLUSH: state_next = FLUSH;
                        default:   state_next = RUN;
                    endcase
                end
            end
            STEP: begin
                state_next = IDLE;
            end
            FLUSH: begin
                // Counter holds the number of flush cycles still to come after this one.
                if (flush_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                end
            end
            HALTED: begin
                if (accept && (cmd_code == CMD_FLUSH)) begin
                    state_next = FLUSH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (halt_hit) begin
            state_next = HALTED;
        end
        if ((state_next == FLUSH) && (state_reg != FLUSH)) begin
            flush_cnt_next = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (pipe_en),
        .clr   (flush_start),
        .count (cycle_count)
    );

endmodule
